// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: pipelined immediate extender for the decode stage.
// Widens an IN_W-bit immediate to OUT_W bits and registers it behind a
// two-entry valid/ready skid buffer.
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   in_valid/in_ready     upstream handshake for in_data/in_mode
//   in_data, in_mode      raw immediate; mode 00 zero, 01 sign, 10 upper, 11 branch
//   out_valid/out_ready   downstream handshake for out_data/out_neg
//   out_data, out_neg     extended immediate and its MSB
//   occupancy             number of results held (0..2)
module imm_ext_pipe #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_neg,
   output logic [1:0]       occupancy
);
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
   state_t           state_q, state_d;
   logic [OUT_W-1:0] sext, ext, main_q, main_d, skid_q, skid_d;
   logic             in_xfer, out_xfer;
   assign sext = {{(OUT_W-IN_W){in_data[IN_W-1]}}, in_data};
   // Branch offsets are word-aligned: shift by 2 and let the top bits fall off.
   always_comb
      ext = in_mode == 2'b00 ? {{(OUT_W-IN_W){1'b0}}, in_data} :
            in_mode == 2'b01 ? sext :
            in_mode == 2'b10 ? {in_data, {(OUT_W-IN_W){1'b0}}} :
                               {sext[OUT_W-3:0], 2'b00};
   // in_ready comes straight from state so out_ready never reaches it combinationally.
   assign in_ready  = state_q != FULL;
   assign out_valid = state_q != EMPTY;
   assign out_data  = main_q;
   assign out_neg   = main_q[OUT_W-1];
   assign occupancy = state_q;
   assign in_xfer   = in_valid & in_ready;
   assign out_xfer  = out_valid & out_ready;
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         EMPTY: if (in_xfer) begin
            state_d = ONE;
            main_d  = ext;
         end
         ONE: if (in_xfer && out_xfer) main_d = ext;
            else if (out_xfer) state_d = EMPTY;
            else if (in_xfer) begin
               state_d = FULL;
               skid_d  = ext;
            end
         FULL: if (out_xfer) begin
            state_d = ONE;
            main_d  = skid_q;
         end
         default: state_d = EMPTY;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
endmodule
